neo_strand_monitor: RTL and testbench
=====================================

Name: neo_strand_monitor

Overview:
- Downstream stage of NeoPixelStrandController: consumes the serial neo_data line and decodes it back into 24-bit GRB pixel words, the same way a physical strand would.
- Used as an on-chip loopback checker and as the scoreboard source in strand-level benches.
- Reports each decoded pixel, frame boundaries (reset gap) and protocol errors.

Parameters:
- NUM_PIXELS, 8: expected pixels per frame; sets the pixel_num width (3 bits at the default).
- BIT_THRESH, 26: high-pulse length in cycles; a pulse of at least this length decodes as 1, a shorter one as 0 (T0H=18, T1H=35 at 50 MHz).
- MIN_HIGH, 5: high pulses shorter than this are glitches and raise an error.
- MAX_HIGH, 60: high pulses longer than this raise an error.
- RESET_LOW, 2500: low run in cycles (50 us) that ends a frame.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- neo_data  in  1  serial strand line from NeoPixelStrandController
- pixel_valid  out  1  one-cycle pulse; pixel_grb and pixel_num are valid
- pixel_grb  out  24  decoded word, G[23:16] R[15:8] B[7:0], MSB received first
- pixel_num  out  $clog2(NUM_PIXELS)  index of the pixel within the current frame
- frame_done  out  1  one-cycle pulse at the end of a frame
- frame_pixels  out  $clog2(NUM_PIXELS)+1  count of complete pixels in the last frame; held until the next frame_done
- frame_error  out  1  sticky; cleared at the first rising edge of the next frame
- overflow  out  1  sticky; more than NUM_PIXELS pixels in the frame; cleared like frame_error

Behaviour:
- Reset (async) clears every output, all counters and the synchronizer flops to 0; state = WAIT_GAP.
- neo_data passes through a 2-flop synchronizer; edges are detected on the synchronized value (d_s vs d_prev). Input-to-detection latency is 2 cycles.
- All outputs are registered. Pulses assert the cycle after the detecting edge and last exactly 1 cycle.
- FSM:
  - WAIT_GAP: count consecutive low cycles; any high clears the count. Count reaching RESET_LOW -> IDLE. A strand that goes active straight out of reset is ignored until a gap is seen.
  - IDLE: rising edge -> HIGH. At this edge: hi_cnt=1, bit_cnt=0, pix_cnt=0, frame_error and overflow cleared.
  - HIGH: hi_cnt++ (saturates at MAX_HIGH+1). On the falling edge:
    - if hi_cnt<MIN_HIGH or hi_cnt>MAX_HIGH: set frame_error, discard the partial pixel, -> WAIT_GAP;
    - otherwise shift bit (hi_cnt>=BIT_THRESH) into the shift register, bit_cnt++, lo_cnt=1, -> LOW.
  - When bit_cnt reaches 24: pixel_valid pulses, pixel_grb = shift register, pixel_num = pix_cnt, pix_cnt++, bit_cnt=0.
  - When pix_cnt already equals NUM_PIXELS: set overflow, no pixel_valid, pix_cnt saturates.
  - LOW: lo_cnt++. A rising edge -> HIGH with hi_cnt=1. lo_cnt reaching RESET_LOW means end of frame:
    - frame_done pulses and frame_pixels = pix_cnt;
    - if bit_cnt!=0, set frame_error (trailing partial pixel dropped);
    - -> IDLE.
- The low-time length inside a frame is not checked (data-period tolerance); only the reset gap matters.
- A pixel_valid and a frame_done never occur in the same cycle: frame_done needs RESET_LOW low cycles after the last bit.
- Reset asserted mid-frame: immediate return to WAIT_GAP; nothing partial is reported after reset releases.

Test Plan:
- Reset, line low for 2500 cycles, then the controller sends 8 pixels each loaded as G=0x12 R=0x34 B=0x56 -> 8 pixel_valid pulses, pixel_grb=24'h123456, pixel_num 0..7, then frame_done with frame_pixels=8, frame_error=0, overflow=0.
- Directed bits, high=18 -> 0 and high=35 -> 1, alternating for 24 bits starting with 1 -> pixel_grb=24'hAAAAAA.
- Boundary widths: high=25 decodes 0, high=26 decodes 1; high=4 -> frame_error=1, no pixel_valid, FSM back to WAIT_GAP; high=61 -> frame_error=1.
- 9 pixels followed by a gap -> 8 pixel_valid pulses, overflow=1, frame_pixels=8. Then send a clean frame -> overflow and frame_error clear at its first rising edge.
- 30 bits then a gap -> 1 pixel_valid, frame_done with frame_pixels=1, frame_error=1.
- Assert reset at bit 12 of pixel 3 -> all outputs 0 immediately. The controller resending without a leading gap produces no decode until 2500 low cycles are seen.

Source files
------------

// File: rtl/neo_strand_monitor.sv
// Decodes a NeoPixel serial strand back into 24-bit GRB pixel words, reporting
// per-pixel results, frame boundaries (reset gaps) and pulse-width protocol errors.
module neo_strand_monitor #(
    parameter int NUM_PIXELS = 8,
    parameter int BIT_THRESH = 26,
    parameter int MIN_HIGH   = 5,
    parameter int MAX_HIGH   = 60,
    parameter int RESET_LOW  = 2500
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          neo_data,
    output logic                          pixel_valid,
    output logic [23:0]                   pixel_grb,
    output logic [$clog2(NUM_PIXELS)-1:0] pixel_num,
    output logic                          frame_done,
    output logic [$clog2(NUM_PIXELS):0]   frame_pixels,
    output logic                          frame_error,
    output logic                          overflow
);

    localparam int PW = $clog2(NUM_PIXELS);
    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int LW = $clog2(RESET_LOW + 1);

    localparam logic [HW-1:0] BIT_T   = HW'(BIT_THRESH);
    localparam logic [HW-1:0] MIN_T   = HW'(MIN_HIGH);
    localparam logic [HW-1:0] MAX_T   = HW'(MAX_HIGH);
    localparam logic [HW-1:0] HI_SAT  = HW'(MAX_HIGH + 1);
    localparam logic [LW-1:0] GAP_END = LW'(RESET_LOW - 1);
    localparam logic [PW:0]   PIX_MAX = (PW + 1)'(NUM_PIXELS);

    typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

    state_t         state;
    logic           sync1;
    logic           d_s;
    logic           d_prev;
    logic [HW-1:0]  hi_cnt;
    logic [LW-1:0]  lo_cnt;
    logic [4:0]     bit_cnt;
    logic [PW:0]    pix_cnt;
    logic [22:0]    shift_reg;

    logic           rise;
    logic           fall;
    logic           bit_val;
    logic [23:0]    new_word;

    assign rise     = d_s & ~d_prev;
    assign fall     = ~d_s & d_prev;
    assign bit_val  = (hi_cnt >= BIT_T);
    assign new_word = {shift_reg, bit_val};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= WAIT_GAP;
            sync1        <= 1'b0;
            d_s          <= 1'b0;
            d_prev       <= 1'b0;
            hi_cnt       <= '0;
            lo_cnt       <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            shift_reg    <= '0;
            pixel_valid  <= 1'b0;
            pixel_grb    <= '0;
            pixel_num    <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            frame_error  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            sync1       <= neo_data;
            d_s         <= sync1;
            d_prev      <= d_s;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;

            case (state)
                // Ignore the line until a full reset gap has been observed.
                WAIT_GAP: begin
                    if (d_s) begin
                        lo_cnt <= '0;
                    end else if (lo_cnt == GAP_END) begin
                        lo_cnt <= '0;
                        state  <= IDLE;
                    end else begin
                        lo_cnt <= lo_cnt + 1'b1;
                    end
                end

                IDLE: begin
                    if (rise) begin
                        hi_cnt      <= HW'(1);
                        bit_cnt     <= '0;
                        pix_cnt     <= '0;
                        frame_error <= 1'b0;
                        overflow    <= 1'b0;
                        state       <= HIGH;
                    end
                end

                HIGH: begin
                    if (fall) begin
                        lo_cnt <= LW'(1);
                        if (hi_cnt < MIN_T || hi_cnt > MAX_T) begin
                            frame_error <= 1'b1;
                            bit_cnt     <= '0;
                            state       <= WAIT_GAP;
                        end else begin
                            shift_reg <= new_word[22:0];
                            state     <= LOW;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                if (pix_cnt == PIX_MAX) begin
                                    overflow <= 1'b1;
                                end else begin
                                    pixel_valid <= 1'b1;
                                    pixel_grb   <= new_word;
                                    pixel_num   <= pix_cnt[PW-1:0];
                                    pix_cnt     <= pix_cnt + 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else if (hi_cnt != HI_SAT) begin
                        hi_cnt <= hi_cnt + 1'b1;
                    end
                end

                // Low time inside a frame is unchecked; only the reset gap ends it.
                LOW: begin
                    if (rise) begin
                        hi_cnt <= HW'(1);
                        state  <= HIGH;
                    end else if (lo_cnt == GAP_END) begin
                        frame_done   <= 1'b1;
                        frame_pixels <= pix_cnt;
                        if (bit_cnt != 5'd0) begin
                            frame_error <= 1'b1;
                        end
                        lo_cnt <= '0;
                        state  <= IDLE;
                    end else begin
                        lo_cnt <= lo_cnt + 1'b1;
                    end
                end

                default: state <= WAIT_GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_neo_strand_monitor.sv
// Scoreboard bench for neo_strand_monitor: directed strand waveforms push expected
// pixels/frames into queues which a monitor process pops and compares.
module tb_neo_strand_monitor;

    logic        clock;
    logic        reset;
    logic        neo_data;
    logic        pixel_valid;
    logic [23:0] pixel_grb;
    logic [2:0]  pixel_num;
    logic        frame_done;
    logic [3:0]  frame_pixels;
    logic        frame_error;
    logic        overflow;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [23:0] grb;
        logic [2:0]  num;
    } pix_t;

    typedef struct {
        logic [3:0] pixels;
        logic       err;
        logic       ovf;
    } frm_t;

    pix_t exp_pix[$];
    frm_t exp_frm[$];

    neo_strand_monitor dut (
        .clock        (clock),
        .reset        (reset),
        .neo_data     (neo_data),
        .pixel_valid  (pixel_valid),
        .pixel_grb    (pixel_grb),
        .pixel_num    (pixel_num),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .frame_error  (frame_error),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive the line to a level for n clock cycles; called and returns at a negedge.
    task automatic drive_level(input logic v, input int n);
        neo_data = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_pulse(input int hi, input int lo);
        drive_level(1'b1, hi);
        drive_level(1'b0, lo);
    endtask

    task automatic send_bits(input logic [23:0] word, input int nbits,
                             input int hi1, input int hi0);
        for (int i = nbits - 1; i >= 0; i--) begin
            send_pulse(word[i] ? hi1 : hi0, 20);
        end
    endtask

    task automatic send_pixel(input logic [23:0] word);
        send_bits(word, 24, 35, 18);
    endtask

    task automatic send_gap();
        drive_level(1'b0, 2600);
    endtask

    task automatic expect_pixel(input logic [23:0] grb, input logic [2:0] num);
        pix_t p;
        p.grb = grb;
        p.num = num;
        exp_pix.push_back(p);
    endtask

    task automatic expect_frame(input logic [3:0] pixels, input logic err, input logic ovf);
        frm_t f;
        f.pixels = pixels;
        f.err    = err;
        f.ovf    = ovf;
        exp_frm.push_back(f);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pixel or frame result.
    always @(negedge clock) begin
        pix_t p;
        frm_t f;
        if (!reset) begin
            if (pixel_valid) begin
                if (exp_pix.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_pixel: got grb 0x%06h num %0d, expected none",
                             pixel_grb, pixel_num);
                end else begin
                    p = exp_pix.pop_front();
                    check_output("pixel_grb", 32'(pixel_grb), 32'(p.grb));
                    check_output("pixel_num", 32'(pixel_num), 32'(p.num));
                end
            end
            if (frame_done) begin
                if (exp_frm.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_frame: got pixels %0d, expected none",
                             frame_pixels);
                end else begin
                    f = exp_frm.pop_front();
                    check_output("frame_pixels", 32'(frame_pixels), 32'(f.pixels));
                    check_output("frame_error",  32'(frame_error),  32'(f.err));
                    check_output("overflow",     32'(overflow),     32'(f.ovf));
                end
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clock);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] ovf_words [9];
        ovf_words = '{24'h010203, 24'h112233, 24'h445566, 24'h778899, 24'hAABBCC,
                      24'hDDEEFF, 24'h0F0F0F, 24'hF0F0F0, 24'hFFFFFF};

        reset    = 1'b1;
        neo_data = 1'b0;
        repeat (3) @(negedge clock);
        check_output("reset_grb", 32'(pixel_grb), 32'h0);
        check_output("reset_flags",
                     32'({pixel_valid, pixel_num, frame_done, frame_pixels, frame_error, overflow}),
                     32'h0);
        reset = 1'b0;
        send_gap();

        $display("[TB] clean frame of 8 pixels 0x123456");
        for (int i = 0; i < 8; i++) expect_pixel(24'h123456, 3'(i));
        expect_frame(4'd8, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_pixel(24'h123456);
        send_gap();

        $display("[TB] alternating bits");
        expect_pixel(24'hAAAAAA, 3'd0);
        expect_frame(4'd1, 1'b0, 1'b0);
        send_pixel(24'hAAAAAA);
        send_gap();

        $display("[TB] threshold widths 26/25");
        expect_pixel(24'hF0F00F, 3'd0);
        expect_frame(4'd1, 1'b0, 1'b0);
        send_bits(24'hF0F00F, 24, 26, 25);
        send_gap();

        $display("[TB] glitch pulse of 4 cycles");
        send_bits(24'h000005, 3, 35, 18);
        send_pulse(4, 20);
        check_output("glitch_error", 32'(frame_error), 32'h1);
        send_bits(24'h123456, 21, 35, 18);
        send_gap();
        check_output("glitch_error_sticky", 32'(frame_error), 32'h1);

        $display("[TB] long pulse of 61 cycles");
        send_bits(24'h000000, 1, 35, 18);
        check_output("error_cleared", 32'(frame_error), 32'h0);
        expect_pixel(24'h123456, 3'd0);
        send_bits(24'h123456, 23, 35, 18);
        send_pulse(61, 20);
        check_output("long_error", 32'(frame_error), 32'h1);
        send_gap();

        $display("[TB] 9 pixels overflow");
        for (int i = 0; i < 8; i++) expect_pixel(ovf_words[i], 3'(i));
        expect_frame(4'd8, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) send_pixel(ovf_words[i]);
        send_gap();
        check_output("overflow_held", 32'(overflow), 32'h1);

        expect_pixel(24'h00FF00, 3'd0);
        expect_frame(4'd1, 1'b0, 1'b0);
        send_bits(24'h000000, 1, 35, 18);
        check_output("overflow_cleared", 32'(overflow), 32'h0);
        send_bits(24'h00FF00, 23, 35, 18);
        send_gap();

        $display("[TB] 30 bits then gap");
        expect_pixel(24'hC3A55A, 3'd0);
        expect_frame(4'd1, 1'b1, 1'b0);
        send_pixel(24'hC3A55A);
        send_bits(24'h00002D, 6, 35, 18);
        send_gap();

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 3; i++) expect_pixel(24'h123456, 3'(i));
        for (int i = 0; i < 3; i++) send_pixel(24'h123456);
        send_bits(24'h123456, 12, 35, 18);
        reset = 1'b1;
        #1;
        check_output("midreset_grb", 32'(pixel_grb), 32'h0);
        check_output("midreset_flags",
                     32'({pixel_valid, pixel_num, frame_done, frame_pixels, frame_error, overflow}),
                     32'h0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        send_pixel(24'h123456);
        send_pixel(24'h654321);
        send_gap();
        expect_pixel(24'h5A5A5A, 3'd0);
        expect_frame(4'd1, 1'b0, 1'b0);
        send_pixel(24'h5A5A5A);
        send_gap();

        repeat (20) @(negedge clock);
        check_output("pixels_pending", 32'(exp_pix.size()), 32'h0);
        check_output("frames_pending", 32'(exp_frm.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
